mdu: RTL and testbench
======================

Name: mdu

Overview:
- Multi-cycle multiply/divide unit for the pipelined MIPS core. It sits beside the combinational ALU in EX and owns the HI/LO architectural registers.
- It executes mult, multu, div, divu, mthi and mtlo.
- It exposes busy so that the hazard unit stalls mfhi, mflo and any new MDU instruction while an operation is in flight.
- The 32-bit operand datapath and the settings-header opcode style match the ALU.

Parameters:
MULT_CYCLES, 5, busy cycles for mult/multu (range 1..31)
DIV_CYCLES, 10, busy cycles for div/divu (range 1..31)

Ports:
clk  input  1  system clock, rising edge
reset_n  input  1  asynchronous, active-low reset
start  input  1  EX-stage request valid, sampled on rising edge
MDUOp  input  3  operation select (MDU* codes)
A  input  32  rs operand
B  input  32  rt operand
busy  output  1  operation in flight
HI  output  32  HI register
LO  output  32  LO register

Behaviour:
- Reset (async, reset_n=0):
  - HI=0, LO=0, busy=0, counter=0, FSM=IDLE.
  - Asserting reset mid-operation aborts the operation; no HI/LO update occurs afterwards.
- FSM states: IDLE, RUN.
- IDLE, start=1, MDUOp=MDUMthi: HI<=A at this edge. No busy. LO unchanged.
- IDLE, start=1, MDUOp=MDUMtlo: LO<=A at this edge. No busy. HI unchanged.
- IDLE, start=1, mult/multu/div/divu:
  - A, B and op are latched at edge E0.
  - FSM moves to RUN and counter loads N (MULT_CYCLES or DIV_CYCLES).
  - busy=1 from E0 through edge E_N, so busy is visibly high for exactly N cycles.
  - The counter decrements each edge. At the edge where counter==1: HI/LO are written, busy->0, FSM->IDLE.
  - The result is readable on HI/LO in the cycle after busy falls.
- RUN, start=1 (any op, including mthi/mtlo): ignored. The hazard unit guarantees this never happens; the block must still not corrupt state.
- Operand changes on A/B during RUN have no effect.
- mult: {HI,LO} = signed(A)*signed(B), full 64-bit result.
- multu: {HI,LO} = unsigned 64-bit product.
- div: LO = quotient truncated toward zero; HI = remainder with the sign of the dividend (A).
  - Example: -7/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - Overflow 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0x00000000.
- divu: LO = A/B, HI = A%B, unsigned.
- Divide by zero (div or divu with B==0):
  - Full DIV_CYCLES latency still applies and busy behaves normally.
  - HI and LO are left unchanged at completion.
- Computation style is free (behavioural * and / in the completion cycle, or an iterative datapath). Only the latency and the results are contractual.
- Invalid MDUOp with start=1 in IDLE: no effect.
- Back-to-back operation: start may be asserted in the cycle busy first reads 0, and is accepted.

Decomposition:
- The shared settings header gains these `define codes:
  - MDUMult=3'd0
  - MDUMultu=3'd1
  - MDUDiv=3'd2
  - MDUDivu=3'd3
  - MDUMthi=3'd4
  - MDUMtlo=3'd5
- Same header also gains the MDU state encodings S_IDLE=1'b0 and S_RUN=1'b1.
- One natural sub-module, mdu_div32: a signed/unsigned divider that returns quotient and remainder and handles the B==0 and overflow cases. Multiply stays inline.

Test Plan:
- Reset mid-op:
  - Preload HI/LO via mthi/mtlo with 0x11111111.
  - mult A=3,B=4; pull reset_n low at busy cycle 2.
  - Expect HI=LO=0 and busy=0 immediately (async). No later update.
- Signed multiply:
  - mult A=0xFFFFFFFF(-1), B=0x00000002.
  - Expect busy high exactly 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFE.
  - Repeat as multu: HI=0x00000001, LO=0xFFFFFFFE.
- Signed divide:
  - div A=-7 (0xFFFFFFF9), B=2.
  - Expect busy 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - divu A=100, B=7: LO=14, HI=2.
- Divide corner cases:
  - mthi 0xAAAA0000, mtlo 0x0000BBBB, then div A=5, B=0.
  - Expect 10 busy cycles and HI/LO unchanged.
  - div 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
- Ignore while busy:
  - During a mult of 6*7, pulse start with mthi A=0xDEADBEEF, and separately with div.
  - Expect busy length unchanged and final HI=0, LO=42.
- mthi/mtlo and back-to-back:
  - mtlo 0x12345678 -> LO updates next edge, busy stays 0.
  - Then start multu 0x10000*0x10000 in the first idle cycle after a prior op.
  - Expect HI=0x00000001, LO=0x00000000.

Source files
------------

// File: rtl/mdu_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mdu_pkg : MDU opcodes, FSM state encoding and shared helpers
// Rev 1.0
// ---------------------------------------------------------------------------
package mdu_pkg;

  localparam logic [2:0] MDUMult  = 3'd0;
  localparam logic [2:0] MDUMultu = 3'd1;
  localparam logic [2:0] MDUDiv   = 3'd2;
  localparam logic [2:0] MDUDivu  = 3'd3;
  localparam logic [2:0] MDUMthi  = 3'd4;
  localparam logic [2:0] MDUMtlo  = 3'd5;

  localparam int CNT_W = 5;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } mdu_state_e;

  function automatic logic [31:0] neg_if(input logic c, input logic [31:0] v);
    return c ? (~v + 32'd1) : v;
  endfunction

  function automatic logic is_div_op(input logic [2:0] op);
    return (op == MDUDiv) || (op == MDUDivu);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mdu_div32.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mdu_div32 : combinational 32-bit signed/unsigned divider (quotient + rem)
// Rev 1.0
// ---------------------------------------------------------------------------
module mdu_div32
  import mdu_pkg::*;
(
  input  logic [31:0] i_dividend,
  input  logic [31:0] i_divisor,
  input  logic        i_signed,
  output logic [31:0] o_quot,
  output logic [31:0] o_rem,
  output logic        o_div_zero
);

  logic        w_a_neg;
  logic        w_b_neg;
  logic [31:0] w_a_mag;
  logic [31:0] w_b_mag;
  logic [31:0] w_b_safe;
  logic [31:0] w_q_mag;
  logic [31:0] w_r_mag;

  assign w_a_neg    = i_signed & i_dividend[31];
  assign w_b_neg    = i_signed & i_divisor[31];
  assign o_div_zero = (i_divisor == 32'd0);

  // 0x80000000 negates to itself, which is its correct unsigned magnitude
  assign w_a_mag  = neg_if(w_a_neg, i_dividend);
  assign w_b_mag  = neg_if(w_b_neg, i_divisor);
  assign w_b_safe = o_div_zero ? 32'd1 : w_b_mag;

  assign w_q_mag = w_a_mag / w_b_safe;
  assign w_r_mag = w_a_mag % w_b_safe;

  assign o_quot = neg_if(w_a_neg ^ w_b_neg, w_q_mag);
  assign o_rem  = neg_if(w_a_neg, w_r_mag);

endmodule
`default_nettype wire

// File: rtl/mdu.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mdu : multi-cycle multiply/divide unit owning the HI/LO registers
// Rev 1.0
// ---------------------------------------------------------------------------
module mdu
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [2:0]  MDUOp,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  mdu_state_e       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_op;
  logic [31:0]      r_a;
  logic [31:0]      r_b;
  logic [31:0]      r_hi;
  logic [31:0]      r_lo;

  mdu_state_e       w_state_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [2:0]       w_op_nxt;
  logic [31:0]      w_a_nxt;
  logic [31:0]      w_b_nxt;
  logic [31:0]      w_hi_nxt;
  logic [31:0]      w_lo_nxt;

  logic             w_mul_signed;
  logic [63:0]      w_a_ext;
  logic [63:0]      w_b_ext;
  logic [63:0]      w_prod;
  logic [31:0]      w_quot;
  logic [31:0]      w_rem;
  logic             w_div_zero;

  // Low 64 bits of a 64x64 product of extended operands give both signed and unsigned results
  assign w_mul_signed = (r_op == MDUMult);
  assign w_a_ext      = {{32{r_a[31] & w_mul_signed}}, r_a};
  assign w_b_ext      = {{32{r_b[31] & w_mul_signed}}, r_b};
  assign w_prod       = w_a_ext * w_b_ext;

  mdu_div32 u_div (
    .i_dividend (r_a),
    .i_divisor  (r_b),
    .i_signed   (r_op == MDUDiv),
    .o_quot     (w_quot),
    .o_rem      (w_rem),
    .o_div_zero (w_div_zero)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_op    <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_op    <= w_op_nxt;
      r_a     <= w_a_nxt;
      r_b     <= w_b_nxt;
      r_hi    <= w_hi_nxt;
      r_lo    <= w_lo_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_op_nxt    = r_op;
    w_a_nxt     = r_a;
    w_b_nxt     = r_b;
    w_hi_nxt    = r_hi;
    w_lo_nxt    = r_lo;

    case (r_state)
      S_IDLE: begin
        if (start) begin
          case (MDUOp)
            MDUMthi: w_hi_nxt = A;
            MDUMtlo: w_lo_nxt = A;
            MDUMult, MDUMultu, MDUDiv, MDUDivu: begin
              w_state_nxt = S_RUN;
              w_cnt_nxt   = is_div_op(MDUOp) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
              w_op_nxt    = MDUOp;
              w_a_nxt     = A;
              w_b_nxt     = B;
            end
            default: ;
          endcase
        end
      end

      S_RUN: begin
        // Requests arriving here are dropped; operands are already latched
        if (r_cnt == CNT_W'(1)) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
          if (is_div_op(r_op)) begin
            if (!w_div_zero) begin
              w_hi_nxt = w_rem;
              w_lo_nxt = w_quot;
            end
          end else begin
            w_hi_nxt = w_prod[63:32];
            w_lo_nxt = w_prod[31:0];
          end
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end

      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign busy = (r_state == S_RUN);
  assign HI   = r_hi;
  assign LO   = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_mdu.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_mdu : self-checking bench for mdu (directed table, corner sequences, random)
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_mdu;
  import mdu_pkg::*;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [2:0]  MDUOp;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic [31:0] HI;
  logic [31:0] LO;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] m_hi;
  logic [31:0] m_lo;

  mdu #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .MDUOp   (MDUOp),
    .A       (A),
    .B       (B),
    .busy    (busy),
    .HI      (HI),
    .LO      (LO)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
  } vec_t;

  vec_t vecs[17];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: plain integer arithmetic on the architectural rules
  task automatic model_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int cyc);
    longint      p;
    longint      q;
    longint      r;
    logic [63:0] pu;
    cyc = 0;
    case (op)
      3'd0: begin p = longint'($signed(a)) * longint'($signed(b)); {m_hi, m_lo} = p; cyc = MC; end
      3'd1: begin pu = {32'd0, a} * {32'd0, b}; {m_hi, m_lo} = pu; cyc = MC; end
      3'd2: begin
        cyc = DC;
        if (b != 0) begin
          q = longint'($signed(a)) / longint'($signed(b));
          r = longint'($signed(a)) % longint'($signed(b));
          m_lo = q[31:0];
          m_hi = r[31:0];
        end
      end
      3'd3: begin
        cyc = DC;
        if (b != 0) begin
          m_lo = a / b;
          m_hi = a % b;
        end
      end
      3'd4: m_hi = a;
      3'd5: m_lo = a;
      default: ;
    endcase
  endtask

  // Caller is at posedge+1; start is sampled at the next edge, so chained calls are back-to-back
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input bit inject, output int cyc);
    start = 1'b1; MDUOp = op; A = a; B = b;
    @(posedge clk); #1;
    start = 1'b0; A = $urandom; B = $urandom; MDUOp = 3'($urandom);
    cyc = 0;
    while (busy && cyc < 64) begin
      cyc++;
      if (inject && cyc == 2) begin
        start = 1'b1; MDUOp = MDUMthi; A = 32'hDEADBEEF;
      end else if (inject && cyc == 3) begin
        start = 1'b1; MDUOp = MDUDiv; A = 32'd100; B = 32'd3;
      end else begin
        start = 1'b0; A = $urandom; B = $urandom;
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
  endtask

  initial begin
    int cyc;
    int exp_cyc;
    logic [2:0]  rop;
    logic [31:0] ra;
    logic [31:0] rb;

    vecs[0]  = '{MDUMult,  32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFE, MC};
    vecs[1]  = '{MDUMultu, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, 32'hFFFFFFFE, MC};
    vecs[2]  = '{MDUMult,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, MC};
    vecs[3]  = '{MDUMultu, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, MC};
    vecs[4]  = '{MDUDiv,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, DC};
    vecs[5]  = '{MDUDiv,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, DC};
    vecs[6]  = '{MDUDivu,  32'd100,      32'd7,        32'd2,        32'd14,       DC};
    vecs[7]  = '{MDUMthi,  32'hAAAA0000, 32'h0,        32'hAAAA0000, 32'd14,       0};
    vecs[8]  = '{MDUMtlo,  32'h0000BBBB, 32'h0,        32'hAAAA0000, 32'h0000BBBB, 0};
    vecs[9]  = '{MDUDiv,   32'd5,        32'd0,        32'hAAAA0000, 32'h0000BBBB, DC};
    vecs[10] = '{MDUDivu,  32'd5,        32'd0,        32'hAAAA0000, 32'h0000BBBB, DC};
    vecs[11] = '{MDUDiv,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, DC};
    vecs[12] = '{MDUMult,  32'd6,        32'd7,        32'h00000000, 32'd42,       MC};
    vecs[13] = '{MDUMtlo,  32'h12345678, 32'h0,        32'h00000000, 32'h12345678, 0};
    vecs[14] = '{MDUMultu, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, MC};
    vecs[15] = '{3'd6,     32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 0};
    vecs[16] = '{3'd7,     32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 0};

    reset_n = 1'b0; start = 1'b0; MDUOp = '0; A = '0; B = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_hi", HI, 32'd0);
    check("reset_lo", LO, 32'd0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Directed table, chained back-to-back
    for (int i = 0; i < 17; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, 1'b0, cyc);
      check($sformatf("vec%0d_cycles", i), cyc, vecs[i].cyc);
      check($sformatf("vec%0d_hi", i), HI, vecs[i].hi);
      check($sformatf("vec%0d_lo", i), LO, vecs[i].lo);
    end

    // Requests during RUN are ignored
    run_op(MDUMthi, 32'h0, 32'h0, 1'b0, cyc);
    run_op(MDUMult, 32'd6, 32'd7, 1'b1, cyc);
    check("ignore_cycles", cyc, MC);
    check("ignore_hi", HI, 32'h0);
    check("ignore_lo", LO, 32'd42);
    repeat (2) @(posedge clk);
    #1;
    check("ignore_idle_busy", {31'd0, busy}, 32'd0);
    check("ignore_idle_hi", HI, 32'h0);

    // Reset in the middle of a multiply
    run_op(MDUMthi, 32'h11111111, 32'h0, 1'b0, cyc);
    run_op(MDUMtlo, 32'h11111111, 32'h0, 1'b0, cyc);
    check("preload_hi", HI, 32'h11111111);
    check("preload_lo", LO, 32'h11111111);
    start = 1'b1; MDUOp = MDUMult; A = 32'd3; B = 32'd4;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #2;
    reset_n = 1'b0;
    #1;
    check("async_rst_busy", {31'd0, busy}, 32'd0);
    check("async_rst_hi", HI, 32'd0);
    check("async_rst_lo", LO, 32'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    check("post_rst_busy", {31'd0, busy}, 32'd0);
    check("post_rst_hi", HI, 32'd0);
    check("post_rst_lo", LO, 32'd0);

    // Random operations against the reference model
    m_hi = 32'd0;
    m_lo = 32'd0;
    for (int i = 0; i < 200; i++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = $urandom;
      case ($urandom_range(0, 5))
        0: rb = 32'd0;
        1: rb = 32'($urandom_range(1, 9));
        2: rb = 32'hFFFFFFFF;
        default: rb = $urandom;
      endcase
      if ($urandom_range(0, 9) == 0) ra = 32'h80000000;
      model_op(rop, ra, rb, exp_cyc);
      run_op(rop, ra, rb, 1'b0, cyc);
      check($sformatf("rnd%0d_op%0d_cycles", i, rop), cyc, exp_cyc);
      check($sformatf("rnd%0d_op%0d_hi", i, rop), HI, m_hi);
      check($sformatf("rnd%0d_op%0d_lo", i, rop), LO, m_lo);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
